// File: rtl/mem_pkg.sv
// Shared word/mask types and byte-enable helper for the memory responder and the cache.
package mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  mask_t;

  // Replicates each byte-enable bit across its 8-bit lane.
  function automatic word_t expand_mask(input mask_t mask);
    word_t w;
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = {8{mask[b]}};
    end
    return w;
  endfunction

endpackage

// File: rtl/pipelined_memory_if.sv
// Memory-side request/response bundle; the master issues requests, the slave is the memory.
interface pipelined_memory_if;
  import mem_pkg::*;

  logic        o_ready;
  logic [31:0] i_addr;
  logic        i_ren;
  logic        i_wen;
  mask_t       i_mask;
  word_t       i_wdata;
  logic        o_valid;
  logic [31:0] o_addr;
  word_t       o_rdata;

  modport master (
    input  o_ready, o_valid, o_addr, o_rdata,
    output i_addr, i_ren, i_wen, i_mask, i_wdata
  );

  modport slave (
    output o_ready, o_valid, o_addr, o_rdata,
    input  i_addr, i_ren, i_wen, i_mask, i_wdata
  );

endinterface

// File: rtl/mem_delay_line.sv
// Fixed-depth shift register carrying a valid bit plus payload; reset clears only the valid bits.
module mem_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= i_valid;
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge i_clk) begin
    data_q[0] <= i_data;
    for (int s = 1; s < DEPTH; s++) begin
      data_q[s] <= data_q[s-1];
    end
  end

  assign o_valid = valid_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];

endmodule

// File: rtl/pipelined_memory.sv
// Word-addressed memory responder: throttled request acceptance, immediate masked writes,
// fixed-latency in-order read responses.
module pipelined_memory
  import mem_pkg::*;
#(
  parameter int SIZE     = 16384,
  parameter int LATENCY  = 4,
  parameter int INTERVAL = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  pipelined_memory_if.slave bus
);

  localparam int AW    = $clog2(SIZE);
  localparam int WORDS = SIZE / 4;
  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(INTERVAL - 1);

  word_t       mem [WORDS];
  logic [AW-3:0] word_idx;
  logic        accept;
  logic        acc_write;
  logic        acc_read;
  word_t       wr_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        pipe_valid;
  logic [63:0] pipe_data;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  word_t       rdata_q, rdata_d;

  assign word_idx  = bus.i_addr[AW-1:2];
  assign bus.o_ready = (cnt_q == '0);
  assign accept    = bus.o_ready & (bus.i_ren | bus.i_wen);
  // A simultaneous read+write is a write only.
  assign acc_write = accept & bus.i_wen;
  assign acc_read  = accept & ~bus.i_wen;
  assign wr_mask   = expand_mask(bus.i_mask);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    valid_d = pipe_valid;
    addr_d  = '0;
    rdata_d = '0;
    if (pipe_valid) begin
      addr_d  = pipe_data[63:32];
      rdata_d = pipe_data[31:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM and survives a mid-operation reset.
  always_ff @(posedge i_clk) begin
    if (acc_write) begin
      mem[word_idx] <= (mem[word_idx] & ~wr_mask) | (bus.i_wdata & wr_mask);
    end
  end

  // Read data is captured at the accept edge, so later writes cannot disturb it.
  mem_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (64)
  ) u_resp_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (acc_read),
    .i_data  ({bus.i_addr, mem[word_idx]}),
    .o_valid (pipe_valid),
    .o_data  (pipe_data)
  );

  assign bus.o_valid = valid_q;
  assign bus.o_addr  = addr_q;
  assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_pipelined_memory.sv
// Self-checking bench for pipelined_memory: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_pipelined_memory;
  import mem_pkg::*;

  localparam int SIZE     = 16384;
  localparam int LATENCY  = 4;
  localparam int INTERVAL = 2;
  localparam int WORDS    = SIZE / 4;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  pipelined_memory_if bus ();

  pipelined_memory #(
    .SIZE     (SIZE),
    .LATENCY  (LATENCY),
    .INTERVAL (INTERVAL)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    word_t       data;
  } resp_t;

  resp_t       exp_q [$];
  word_t       model_mem [WORDS];
  word_t       pool_val [17];
  int          errors = 0;
  int          checks = 0;
  int          edge_n = 0;
  int          last_accept = 0;
  bit          have_acc = 1'b0;
  bit          last_acc = 1'b0;
  int          resp_count = 0;
  int          last_resp_edge = 0;
  word_t       last_rdata = '0;
  logic [31:0] last_raddr = '0;
  logic [31:0] resp_addr_log [$];
  int          resp_edge_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a % 32'(SIZE)) / 32'd4);
  endfunction

  function automatic word_t merge(input word_t old, input word_t d, input mask_t m);
    word_t r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Ready returns INTERVAL-1 edges after the most recent accept.
  function automatic bit model_ready();
    return !have_acc || (edge_n >= last_accept + INTERVAL - 1);
  endfunction

  task automatic idle();
    bus.i_ren   = 1'b0;
    bus.i_wen   = 1'b0;
    bus.i_addr  = '0;
    bus.i_mask  = '0;
    bus.i_wdata = '0;
  endtask

  // One clock edge: update the model with whatever is presented, then check all outputs.
  task automatic tick();
    bit          acc;
    bit          wr;
    logic [31:0] a;
    mask_t       m;
    word_t       d;
    bit          exp_v;
    resp_t       r;
    acc = model_ready() && (bus.i_ren || bus.i_wen);
    wr  = bus.i_wen;
    a   = bus.i_addr;
    m   = bus.i_mask;
    d   = bus.i_wdata;
    @(posedge i_clk);
    edge_n++;
    last_acc = acc;
    if (acc) begin
      last_accept = edge_n;
      have_acc    = 1'b1;
      if (wr) begin
        model_mem[widx(a)] = merge(model_mem[widx(a)], d, m);
      end else begin
        r.due  = edge_n + LATENCY;
        r.addr = a;
        r.data = model_mem[widx(a)];
        exp_q.push_back(r);
      end
    end
    #1;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
    check("ready", 32'(bus.o_ready), 32'(model_ready()));
    check("valid", 32'(bus.o_valid), 32'(exp_v));
    if (exp_v) begin
      r = exp_q.pop_front();
      check("resp_addr", bus.o_addr, r.addr);
      check("resp_rdata", bus.o_rdata, r.data);
      resp_count++;
      last_resp_edge = edge_n;
      last_rdata     = bus.o_rdata;
      last_raddr     = bus.o_addr;
      resp_addr_log.push_back(bus.o_addr);
      resp_edge_log.push_back(edge_n);
    end else begin
      check("idle_addr", bus.o_addr, 32'h0);
      check("idle_rdata", bus.o_rdata, 32'h0);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // Presents a request until it is accepted (bounded), then goes idle.
  task automatic do_req(input bit ren, input bit wen, input logic [31:0] addr,
                        input mask_t mask, input word_t data);
    int n = 0;
    bus.i_ren   = ren;
    bus.i_wen   = wen;
    bus.i_addr  = addr;
    bus.i_mask  = mask;
    bus.i_wdata = data;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) check("req_timeout", 32'(last_acc), 32'h1);
    idle();
  endtask

  task automatic wait_resp(input int base);
    int n = 0;
    while (resp_count == base && n < 3 * LATENCY + 4) begin
      tick();
      n++;
    end
    if (resp_count == base) check("resp_timeout", 32'(resp_count), 32'(base + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_edge;
    int rc;
    int accs;
    idle();
    #2;
    check("rst_ready", 32'(bus.o_ready), 32'h1);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_addr", bus.o_addr, 32'h0);
    check("rst_rdata", bus.o_rdata, 32'h0);
    repeat (2) @(posedge i_clk);
    #5;
    i_rst_n = 1'b1;

    // Known contents for words 0..16; word 0x10 (byte 0x40) holds 0x12345678.
    for (int i = 0; i <= 16; i++) begin
      pool_val[i] = (i == 16) ? 32'h12345678 : $urandom();
      do_req(1'b0, 1'b1, 32'(i * 4), 4'hF, pool_val[i]);
    end

    // Basic read latency and single-cycle pulse.
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h40, 4'h0, '0);
    acc_edge = edge_n;
    wait_resp(rc);
    check("lat_cycles", 32'(last_resp_edge - acc_edge), 32'(LATENCY));
    check("lat_addr", last_raddr, 32'h40);
    check("lat_rdata", last_rdata, 32'h12345678);
    tick();
    check("lat_pulse", 32'(bus.o_valid), 32'h0);

    // Masked write merge.
    do_req(1'b0, 1'b1, 32'h80, 4'hF, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'h80, 4'h3, 32'h0000CAFE);
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h80, 4'h0, '0);
    wait_resp(rc);
    check("mask_rdata", last_rdata, 32'hDEADCAFE);

    // Throttle: ren held six cycles with a new address each cycle.
    drain(3);
    rc = resp_count;
    accs = 0;
    resp_addr_log.delete();
    resp_edge_log.delete();
    for (int i = 0; i < 6; i++) begin
      bus.i_ren  = 1'b1;
      bus.i_addr = 32'(i * 4);
      tick();
      if (last_acc) accs++;
    end
    idle();
    drain(LATENCY + 3);
    check("thr_accepts", 32'(accs), 32'd3);
    check("thr_resps", 32'(resp_count - rc), 32'd3);
    if (resp_addr_log.size() == 3) begin
      check("thr_addr0", resp_addr_log[0], 32'h0);
      check("thr_addr1", resp_addr_log[1], 32'h8);
      check("thr_addr2", resp_addr_log[2], 32'h10);
      check("thr_gap01", 32'(resp_edge_log[1] - resp_edge_log[0]), 32'd2);
      check("thr_gap12", 32'(resp_edge_log[2] - resp_edge_log[1]), 32'd2);
    end else begin
      check("thr_log_size", 32'(resp_addr_log.size()), 32'd3);
    end

    // Ordering: read sees earlier write, not a later one.
    do_req(1'b0, 1'b1, 32'h100, 4'hF, 32'hAAAAAAAA);
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h100, 4'h0, '0);
    wait_resp(rc);
    check("ord_raw", last_rdata, 32'hAAAAAAAA);
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h100, 4'h0, '0);
    do_req(1'b0, 1'b1, 32'h100, 4'hF, 32'h55555555);
    wait_resp(rc);
    check("ord_war", last_rdata, 32'hAAAAAAAA);
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h100, 4'h0, '0);
    wait_resp(rc);
    check("ord_after", last_rdata, 32'h55555555);

    // Address wrap and simultaneous read+write.
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h4000, 4'h0, '0);
    wait_resp(rc);
    check("wrap_rdata", last_rdata, pool_val[0]);
    check("wrap_addr", last_raddr, 32'h4000);
    rc = resp_count;
    do_req(1'b1, 1'b1, 32'h200, 4'hF, 32'h0BADF00D);
    drain(LATENCY + 2);
    check("dual_no_resp", 32'(resp_count - rc), 32'd0);
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h200, 4'h0, '0);
    wait_resp(rc);
    check("dual_written", last_rdata, 32'h0BADF00D);

    // Reset with a read in flight.
    do_req(1'b0, 1'b1, 32'h300, 4'hF, 32'h600DCAFE);
    do_req(1'b1, 1'b0, 32'h300, 4'h0, '0);
    drain(2);
    #4;
    i_rst_n = 1'b0;
    exp_q.delete();
    have_acc = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.o_ready), 32'h1);
    check("mid_rst_valid", 32'(bus.o_valid), 32'h0);
    rc = resp_count;
    tick();
    #4;
    i_rst_n = 1'b1;
    drain(LATENCY + 3);
    check("mid_rst_flushed", 32'(resp_count - rc), 32'd0);
    rc = resp_count;
    do_req(1'b1, 1'b0, 32'h300, 4'h0, '0);
    wait_resp(rc);
    check("mid_rst_persist", last_rdata, 32'h600DCAFE);

    // Randomized traffic over the known words, with random upper and low address bits.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      bus.i_ren   = (sel <= 3) || (sel == 7);
      bus.i_wen   = (sel >= 4) && (sel <= 7);
      bus.i_addr  = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 16)) << 2) | ($urandom() & 32'h3);
      bus.i_mask  = mask_t'($urandom());
      bus.i_wdata = $urandom();
      tick();
    end
    idle();
    drain(LATENCY + 3);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_memory.md
# pipelined_memory

Synthesizable word-addressed memory responder: the target end of the cache's memory-side request/response interface. Accepts one read or write per `INTERVAL` cycles, commits masked writes immediately and returns read data with a fixed `LATENCY`. Replaces the behavioural memory model in cache and core benches, and serves as the FPGA main-memory stub.

## Interface
- `SIZE`, 16384: capacity in bytes; power of two, ≥ 8.
- `LATENCY`, 4: cycles from read acceptance to response; ≥ 1.
- `INTERVAL`, 2: minimum cycles between accepted requests; ≥ 1.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `o_ready`  out  1  request is accepted this cycle if `i_ren|i_wen`.
- `i_addr`  in  32  byte address; `[1:0]` ignored.
- `i_ren`  in  1  read request.
- `i_wen`  in  1  write request.
- `i_mask`  in  4  byte enables for writes; bit n → `i_wdata[8n+7:8n]`.
- `i_wdata`  in  32  write data.
- `o_valid`  out  1  read response valid, one-cycle pulse.
- `o_addr`  out  32  full request address of the response.
- `o_rdata`  out  32  read data.

## Operation
- Storage is array `mem`, `SIZE/4` words of 32 bits, indexed by `i_addr[$clog2(SIZE)-1:2]`. Upper address bits are ignored, so addresses wrap modulo `SIZE`. The array name is fixed so benches can preload it with `$readmemh`.
- Accept = `o_ready & (i_ren | i_wen)`. Requests made while `o_ready` = 0 are dropped. No queueing, no error.
- Write: on the accept edge, bytes with a set mask bit are updated. `i_mask` = 0 is accepted and changes nothing. Writes produce no response.
- Read: the word is sampled on the accept edge. The read observes every write accepted earlier and is unaffected by later writes. `i_mask` is ignored; the full word is returned.
- `i_ren & i_wen` together: treated as a write only; no response.
- Ready throttle: a down-counter loads `INTERVAL-1` on accept. `o_ready` = (counter == 0). With `INTERVAL` = 1, `o_ready` stays high.
- Response pipe: a `LATENCY`-stage shift register of {valid, addr, data}. It sustains ⌈`LATENCY`/`INTERVAL`⌉ reads in flight with no stall. Responses return in order.
- When `o_valid` = 0, `o_addr` and `o_rdata` are 0.

## Timing
- Reset (`i_rst_n` low, asynchronous): `o_ready` = 1, `o_valid` = 0, `o_addr` = 0, `o_rdata` = 0, throttle counter = 0, all pipe stages invalid. The `mem` contents are NOT cleared.
- Reset asserted mid-operation flushes in-flight reads; they never produce `o_valid`. Writes already accepted remain in `mem`.
- First accept is possible on the first rising edge after `i_rst_n` rises.
- Read accepted at edge k:
  - `o_valid`, `o_addr` and `o_rdata` are registered outputs, high in the cycle following edge k+`LATENCY`.
  - `o_valid` drops after edge k+`LATENCY`+1.
- Accept at edge k:
  - `o_ready` is low after edge k for `INTERVAL-1` cycles.
  - `o_ready` is high again after edge k+`INTERVAL`-1.
  - The next accept is possible at edge k+`INTERVAL`.
- A write accepted at the same edge a read response leaves the pipe does not affect that response.
- Back-to-back reads at `INTERVAL` spacing produce `o_valid` pulses at the same spacing.

## Structure
- Package `mem_pkg`:
  - `word_t` (logic [31:0]).
  - `mask_t` (logic [3:0]).
  - Function `expand_mask(mask_t) → word_t` (byte → 8-bit replicate), shared with the cache.
- Sub-module `mem_delay_line`:
  - Parameterized depth and payload width.
  - Async active-low reset clears the valid bits only.
  - Holds the response pipe.
- The top level holds the array, accept logic, throttle counter and output zeroing.
- Target: 150–250 lines total.

## Test plan
- Reset, then check outputs; preload word 0x10 with 0x12345678 via `$readmemh`. Expect `o_ready` = 1, `o_valid` = 0, `o_addr`/`o_rdata` = 0. Read 0x40 → `o_valid` exactly 4 cycles after accept, `o_addr` = 0x40, `o_rdata` = 0x12345678, one-cycle pulse.
- Masked write: write 0xDEADBEEF, mask 1111, to 0x80; then 0x0000CAFE, mask 0011. Read 0x80 → 0xDEADCAFE.
- Throttle (`INTERVAL` = 2): hold `i_ren` high for 6 cycles on 0x0, 0x4, …, changing address every cycle. Exactly 3 accepts and 3 responses, 2 cycles apart, carrying the addresses presented at the accept edges.
- Ordering: write 0xAAAAAAAA to 0x100, then read 0x100 at the next ready → 0xAAAAAAAA. Then read 0x100, write 0x55555555 to 0x100 at the next ready → response 0xAAAAAAAA.
- Wrap and dual request: read 0x4000 (`SIZE` = 16384) → returns the word at 0x0. Assert `i_ren` and `i_wen` together → write happens, no `o_valid`.
- Reset mid-flight: accept a read, pull `i_rst_n` low 2 cycles later for 1 cycle → no `o_valid` afterwards, `o_ready` = 1 immediately, a prior write persists on readback.
